// File: rtl/miter_pkg.sv
// rtl/miter_pkg.sv - shared types and constants for the miter sweep controller
package miter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Number of stimulus vectors in one exhaustive sweep.
  function automatic int vec_count(input int data_w);
    return 1 << data_w;
  endfunction

  // Largest value a saturating counter of cnt_w bits may hold.
  function automatic int sat_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/miter_sweep_ctrl_if.sv
// rtl/miter_sweep_ctrl_if.sv - host/datapath-facing bus of the miter sweep controller
interface miter_sweep_ctrl_if #(
  parameter int DATA_W = 2,
  parameter int Q_W    = 1,
  parameter int CNT_W  = 8
);

  logic              start;
  logic [DATA_W-1:0] data;
  logic [Q_W-1:0]    q1;
  logic [Q_W-1:0]    q2;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  mism_cnt;
  logic              first_fail_valid;
  logic [DATA_W-1:0] first_fail_vec;

  modport master (
    input  start, q1, q2,
    output data, busy, done, pass, mism_cnt, first_fail_valid, first_fail_vec
  );

  modport slave (
    output start, q1, q2,
    input  data, busy, done, pass, mism_cnt, first_fail_valid, first_fail_vec
  );

endinterface

// File: rtl/miter_vec_gen.sv
// rtl/miter_vec_gen.sv - stimulus vector counter with last-vector flag and settle wait counter
module miter_vec_gen
  import miter_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int LAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              clear,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              settled
);

  localparam logic [DATA_W:0] LAST_VEC = (DATA_W+1)'(vec_count(DATA_W) - 1);

  // One spare bit so the counter can never alias back to vector 0 mid-sweep.
  logic [DATA_W:0] vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else if (clear) begin
      vec <= '0;
    end else if (advance) begin
      vec <= vec + (DATA_W+1)'(1);
    end
  end

  assign data = vec[DATA_W-1:0];
  assign last = (vec == LAST_VEC);

  generate
    if (LAT == 0) begin : g_no_wait
      assign settled = 1'b1;
    end else begin : g_wait
      localparam int WAIT_W = $clog2(LAT + 1);
      localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(LAT - 1);

      logic [WAIT_W-1:0] wait_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wait_cnt <= '0;
        end else if (clear || advance) begin
          wait_cnt <= '0;
        end else if (wait_cnt != WAIT_END) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end

      assign settled = (wait_cnt == WAIT_END);
    end
  endgenerate

endmodule

// File: rtl/miter_sweep_ctrl.sv
// rtl/miter_sweep_ctrl.sv - exhaustive-stimulus equivalence sweep of a golden/rewritten datapath pair; option MITER_STOP_ON_FAIL_EN
module miter_sweep_ctrl
  import miter_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int Q_W    = 1,
  parameter int LAT    = 0,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  miter_sweep_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(sat_max(CNT_W));
  localparam state_t           AFTER_STEP = (LAT > 0) ? SETTLE : CHECK;

  state_t            state;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              settled;
  logic              advance;
  logic              clear;
  logic              finish;
  logic              mismatch;
  logic [Q_W-1:0]    q_diff;

  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  mism_cnt;
  logic              ff_valid;
  logic [DATA_W-1:0] ff_vec;

  assign q_diff   = bus.q1 ^ bus.q2;
  assign mismatch = |q_diff;
  assign clear    = ((state == IDLE) || (state == DONE)) && bus.start;

`ifdef MITER_STOP_ON_FAIL_EN
  assign finish = last || mismatch;
`else
  assign finish = last;
`endif

  assign advance = (state == CHECK) && !finish;

  miter_vec_gen #(
    .DATA_W(DATA_W),
    .LAT   (LAT)
  ) u_vec_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(advance),
    .clear  (clear),
    .data   (data),
    .last   (last),
    .settled(settled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mism_cnt <= '0;
      ff_valid <= 1'b0;
      ff_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mism_cnt <= '0;
            ff_valid <= 1'b0;
            ff_vec   <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state    <= AFTER_STEP;
          end
        end
        SETTLE: begin
          if (settled) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (mism_cnt != CNT_MAX) begin
              mism_cnt <= mism_cnt + CNT_W'(1);
            end
            if (!ff_valid) begin
              ff_valid <= 1'b1;
              ff_vec   <= data;
            end
          end
          // The verdict must include this cycle's compare, not just the registered count.
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (mism_cnt == '0);
          end else begin
            state <= AFTER_STEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data             = data;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.mism_cnt         = mism_cnt;
  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_vec   = ff_vec;

endmodule

// File: tb/tb_miter_sweep_ctrl.sv
// tb/tb_miter_sweep_ctrl.sv - scoreboard bench for miter_sweep_ctrl (three parameter sets, honours MITER_STOP_ON_FAIL_EN)
module tb_miter_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  miter_sweep_ctrl_if #(.DATA_W(2), .Q_W(1), .CNT_W(8)) b0 ();
  miter_sweep_ctrl_if #(.DATA_W(2), .Q_W(1), .CNT_W(8)) b1 ();
  miter_sweep_ctrl_if #(.DATA_W(3), .Q_W(1), .CNT_W(2)) b2 ();

  miter_sweep_ctrl #(.DATA_W(2), .Q_W(1), .LAT(0), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  miter_sweep_ctrl #(.DATA_W(2), .Q_W(1), .LAT(2), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  miter_sweep_ctrl #(.DATA_W(3), .Q_W(1), .LAT(0), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // Datapath pair models: mode 0 equivalent, 1 fully broken, 2 fault at vector 2 only.
  int mode0 = 0;
  always_comb begin
    b0.q1 = ~b0.data[0];
    case (mode0)
      1:       b0.q2 = b0.data[0];
      2:       b0.q2 = (b0.data == 2'd2) ? b0.data[0] : ~b0.data[0];
      default: b0.q2 = ~b0.data[0];
    endcase
  end
  assign b1.q1 = ~b1.data[0];
  assign b1.q2 = ~b1.data[0];
  assign b2.q1 = b2.data[0];
  assign b2.q2 = ~b2.data[0];

  typedef struct {
    logic [31:0] data, busy, done, pass, mism, ffv, ffvec;
  } obs_t;

  typedef struct {
    logic [31:0] data, pass, mism, ffv, ffvec;
  } res_t;

  logic [31:0] exp_q[$];
  res_t        res_q[$];
  int          vectors = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input int i);
    obs_t o;
    case (i)
      0: begin
        o.data = b0.data; o.busy = b0.busy; o.done = b0.done; o.pass = b0.pass;
        o.mism = b0.mism_cnt; o.ffv = b0.first_fail_valid; o.ffvec = b0.first_fail_vec;
      end
      1: begin
        o.data = b1.data; o.busy = b1.busy; o.done = b1.done; o.pass = b1.pass;
        o.mism = b1.mism_cnt; o.ffv = b1.first_fail_valid; o.ffvec = b1.first_fail_vec;
      end
      default: begin
        o.data = b2.data; o.busy = b2.busy; o.done = b2.done; o.pass = b2.pass;
        o.mism = b2.mism_cnt; o.ffv = b2.first_fail_valid; o.ffvec = b2.first_fail_vec;
      end
    endcase
    return o;
  endfunction

  task automatic set_start(input int i, input logic v);
    case (i)
      0:       b0.start = v;
      1:       b1.start = v;
      default: b2.start = v;
    endcase
  endtask

  function automatic bit model_fail(input int i, input int mode, input int v);
    if (i == 1) return 1'b0;
    if (i == 2) return 1'b1;
    return (mode == 1) || (mode == 2 && v == 2);
  endfunction

  // Expected data per cycle and the final result of one sweep.
  function automatic void push_expected(input int i, input int mode);
    int   dw   = (i == 2) ? 3 : 2;
    int   lat  = (i == 1) ? 2 : 0;
    int   cmax = (i == 2) ? 3 : 255;
    int   mism = 0;
    int   ffv = 0;
    int   ffvec = 0;
    int   last_v = 0;
    res_t r;
    for (int v = 0; v < (1 << dw); v++) begin
      for (int k = 0; k <= lat; k++) exp_q.push_back(v);
      last_v = v;
      if (model_fail(i, mode, v)) begin
        if (mism < cmax) mism++;
        if (ffv == 0) begin
          ffv = 1;
          ffvec = v;
        end
`ifdef MITER_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    r.data = last_v;
    r.pass = (mism == 0);
    r.mism = mism;
    r.ffv = ffv;
    r.ffvec = ffvec;
    res_q.push_back(r);
  endfunction

  task automatic sweep(input int i, input int mode, input int poke_at);
    obs_t        o;
    res_t        r;
    logic [31:0] e;
    int          n = 0;
    if (i == 0) mode0 = mode;
    push_expected(i, mode);
    @(negedge clk);
    set_start(i, 1'b1);
    @(negedge clk);
    set_start(i, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = sample(i);
      chk($sformatf("u%0d m%0d data@%0d", i, mode, n), o.data, e);
      chk($sformatf("u%0d m%0d busy@%0d", i, mode, n), o.busy, 1);
      chk($sformatf("u%0d m%0d done@%0d", i, mode, n), o.done, 0);
      set_start(i, n == poke_at);
      @(negedge clk);
      n++;
    end
    set_start(i, 1'b0);
    r = res_q.pop_front();
    o = sample(i);
    chk($sformatf("u%0d m%0d done", i, mode), o.done, 1);
    chk($sformatf("u%0d m%0d busy_end", i, mode), o.busy, 0);
    chk($sformatf("u%0d m%0d pass", i, mode), o.pass, r.pass);
    chk($sformatf("u%0d m%0d mism_cnt", i, mode), o.mism, r.mism);
    chk($sformatf("u%0d m%0d ff_valid", i, mode), o.ffv, r.ffv);
    chk($sformatf("u%0d m%0d ff_vec", i, mode), o.ffvec, r.ffvec);
    chk($sformatf("u%0d m%0d data_end", i, mode), o.data, r.data);
  endtask

  task automatic chk_zero(input string tag, input int i);
    obs_t o = sample(i);
    chk({tag, " data"}, o.data, 0);
    chk({tag, " busy"}, o.busy, 0);
    chk({tag, " done"}, o.done, 0);
    chk({tag, " pass"}, o.pass, 0);
    chk({tag, " mism_cnt"}, o.mism, 0);
    chk({tag, " ff_valid"}, o.ffv, 0);
    chk({tag, " ff_vec"}, o.ffvec, 0);
  endtask

  initial begin
    b0.start = 1'b0;
    b1.start = 1'b0;
    b2.start = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset u0", 0);
    chk_zero("reset u1", 1);
    chk_zero("reset u2", 2);
    rst_n = 1'b1;

    sweep(0, 0, 1);
    sweep(0, 1, -1);
    sweep(0, 2, -1);
    sweep(1, 0, -1);
    sweep(2, 0, -1);

    // Reset in the middle of an equivalent sweep, at vector 2.
    mode0 = 0;
    @(negedge clk);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    for (int k = 0; k < 20 && b0.data != 2'd2; k++) @(negedge clk);
    chk("midreset reached vec2", b0.data, 2);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset u0", 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
